// File: rtl/mem_pkg.sv
// Shared defaults, external-memory region map and FSM state encoding.
package mem_pkg;

  localparam int unsigned NREQ_DEFAULT       = 4;
  localparam int unsigned ADDR_W_DEFAULT     = 32;
  localparam int unsigned DATA_W_DEFAULT     = 32;
  localparam int unsigned RD_TIMEOUT_DEFAULT = 255;

  // External-memory region base offsets
  localparam logic [31:0] REGION_0 = 32'h0000_0000;  // 0 MiB
  localparam logic [31:0] REGION_1 = 32'h0020_0000;  // 2 MiB
  localparam logic [31:0] REGION_2 = 32'h0040_0000;  // 4 MiB
  localparam logic [31:0] REGION_3 = 32'h0060_0000;  // 6 MiB
  localparam logic [31:0] REGION_4 = 32'h01A0_0000;  // 26 MiB
  localparam logic [31:0] REGION_5 = 32'h02C0_0000;  // 44 MiB

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BEAT    = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first request at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]                          req_i,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr_i,
  output logic [NREQ-1:0]                          win_c_o
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic        found;
  int unsigned idx;

  // Scan upward from the pointer, keep only the first hit
  always_comb begin
    win_c_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_i) + k) % NREQ;
      if (!found && req_i[IDX_W'(idx)]) begin
        win_c_o[IDX_W'(idx)] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/extmem_arbiter.sv
// Burst arbiter: NREQ requesters share one single-outstanding external memory port.
module extmem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned NREQ       = NREQ_DEFAULT,
  parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W     = DATA_W_DEFAULT,
  parameter int unsigned RD_TIMEOUT = RD_TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0]              we_i,
  input  logic [NREQ-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NREQ-1:0][7:0]         len_i,
  input  logic [NREQ-1:0][DATA_W-1:0]  wdata_i,
  output logic [NREQ-1:0]              gnt_o,
  output logic [NREQ-1:0]              rvalid_o,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         request_extmem,
  output logic                         write_extmem,
  output logic [ADDR_W-1:0]            addr_extmem,
  output logic [DATA_W-1:0]            w_data,
  input  logic                         valid_extmem,
  input  logic [DATA_W-1:0]            data_extmem,
  output logic                         busy_o,
  output logic                         err_timeout_o,
  output logic [63:0]                  measure_cnt_busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          beat_q, beat_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req_ext_q, req_ext_d;
  logic                wr_ext_q, wr_ext_d;
  logic [ADDR_W-1:0]   addr_ext_q, addr_ext_d;
  logic [DATA_W-1:0]   wdata_ext_q, wdata_ext_d;
  logic                busy_q, busy_d;
  logic [63:0]         cnt_q, cnt_d;
  logic                burst_end;
  logic [NREQ-1:0]     win_oh;
  logic [IDX_W-1:0]    win_idx;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .win_c_o (win_oh)
  );

  // One-hot winner to index
  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_oh[i]) win_idx = IDX_W'(i);
    end
  end

  // Next-state, burst bookkeeping and registered-output staging
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    we_d        = we_q;
    base_d      = base_q;
    len_d       = len_q;
    beat_d      = beat_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    burst_end   = 1'b0;
    gnt_d       = '0;
    req_ext_d   = 1'b0;
    wr_ext_d    = 1'b0;
    addr_ext_d  = addr_ext_q;
    wdata_ext_d = wdata_ext_q;

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d = ST_BEAT;
          owner_d = win_idx;
          we_d    = we_i[win_idx];
          base_d  = addr_i[win_idx];
          len_d   = (len_i[win_idx] == 8'd0) ? 8'd1 : len_i[win_idx];
          beat_d  = 8'd0;
        end
      end
      ST_BEAT: begin
        if (we_q) begin
          if (beat_q + 8'd1 == len_q) begin
            state_d   = ST_IDLE;
            burst_end = 1'b1;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end else begin
          state_d = ST_WAIT_RD;
          beat_d  = beat_q + 8'd1;
          tmo_d   = '0;
        end
      end
      ST_WAIT_RD: begin
        if (valid_extmem) begin
          rvalid_d = NREQ'(1) << owner_q;
          rdata_d  = data_extmem;
          if (beat_q == len_q) begin
            state_d   = ST_IDLE;
            burst_end = 1'b1;
          end else begin
            state_d = ST_BEAT;
          end
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
          // Abandon the burst: flag it and hand back a zero beat
          rvalid_d  = NREQ'(1) << owner_q;
          rdata_d   = '0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
          burst_end = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (burst_end) begin
      ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
    end

    // Strobe/grant registers are loaded so they are high exactly during BEAT
    if (state_d == ST_BEAT) begin
      gnt_d       = NREQ'(1) << owner_d;
      req_ext_d   = 1'b1;
      wr_ext_d    = we_d;
      addr_ext_d  = base_d + ADDR_W'(beat_d);
      wdata_ext_d = wdata_i[owner_d];
    end

    busy_d = (state_d != ST_IDLE);
    cnt_d  = (busy_q && (cnt_q != '1)) ? cnt_q + 64'd1 : cnt_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      we_q        <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      req_ext_q   <= 1'b0;
      wr_ext_q    <= 1'b0;
      addr_ext_q  <= '0;
      wdata_ext_q <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      base_q      <= base_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      req_ext_q   <= req_ext_d;
      wr_ext_q    <= wr_ext_d;
      addr_ext_q  <= addr_ext_d;
      wdata_ext_q <= wdata_ext_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt_o            = gnt_q;
  assign rvalid_o         = rvalid_q;
  assign rdata_o          = rdata_q;
  assign request_extmem   = req_ext_q;
  assign write_extmem     = wr_ext_q;
  assign addr_extmem      = addr_ext_q;
  assign w_data           = wdata_ext_q;
  assign busy_o           = busy_q;
  assign err_timeout_o    = err_q;
  assign measure_cnt_busy = cnt_q;

endmodule

// File: tb/tb_extmem_arbiter.sv
// Directed bench for extmem_arbiter with a 2-cycle-latency memory responder.
module tb_extmem_arbiter;
  import mem_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NREQ-1:0]             req_i, we_i;
  logic [NREQ-1:0][ADDR_W-1:0] addr_i;
  logic [NREQ-1:0][7:0]        len_i;
  logic [NREQ-1:0][DATA_W-1:0] wdata_i;
  logic [NREQ-1:0]             gnt_o, rvalid_o;
  logic [DATA_W-1:0]           rdata_o, w_data, data_extmem;
  logic                        request_extmem, write_extmem, valid_extmem;
  logic [ADDR_W-1:0]           addr_extmem;
  logic                        busy_o, err_timeout_o;
  logic [63:0]                 measure_cnt_busy;

  always #5 clk = ~clk;

  extmem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .len_i(len_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .request_extmem(request_extmem), .write_extmem(write_extmem), .addr_extmem(addr_extmem),
    .w_data(w_data), .valid_extmem(valid_extmem), .data_extmem(data_extmem),
    .busy_o(busy_o), .err_timeout_o(err_timeout_o), .measure_cnt_busy(measure_cnt_busy)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  logic [31:0] st_addr[$];
  logic        st_we[$];
  logic [31:0] st_wd[$];
  int unsigned st_cyc[$];
  logic [3:0]  gnt_log[$];
  int unsigned gnt_cyc[$];
  logic [3:0]  rv_log[$];
  logic [31:0] rv_data[$];
  int unsigned rv_cyc[$];

  logic        mem_en, force_valid;
  int          mem_dly;
  logic [31:0] mem_pend;
  int unsigned wcnt[NREQ];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_wdata();
    for (int i = 0; i < NREQ; i++)
      wdata_i[i] = 32'hD000_0000 | (32'(i) << 16) | 32'(wcnt[i]);
  endtask

  task automatic clear_logs();
    st_addr.delete(); st_we.delete(); st_wd.delete(); st_cyc.delete();
    gnt_log.delete(); gnt_cyc.delete();
    rv_log.delete(); rv_data.delete(); rv_cyc.delete();
    mem_dly = 0;
    for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
    set_wdata();
  endtask

  // One clock: sample just after the edge, then update responder and requesters
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (request_extmem) begin
      st_addr.push_back(addr_extmem); st_we.push_back(write_extmem);
      st_wd.push_back(w_data); st_cyc.push_back(cyc);
    end
    if (gnt_o != '0) begin gnt_log.push_back(gnt_o); gnt_cyc.push_back(cyc); end
    if (rvalid_o != '0) begin
      rv_log.push_back(rvalid_o); rv_data.push_back(rdata_o); rv_cyc.push_back(cyc);
    end
    valid_extmem = 1'b0;
    data_extmem  = '0;
    if (force_valid) begin valid_extmem = 1'b1; data_extmem = 32'hDEAD_BEEF; end
    if (mem_dly > 0) begin
      mem_dly--;
      if (mem_dly == 0) begin valid_extmem = 1'b1; data_extmem = mem_pend; end
    end
    if (mem_en && request_extmem && !write_extmem) begin
      mem_dly  = 2;
      mem_pend = addr_extmem ^ 32'h5A5A_5A5A;
    end
    for (int i = 0; i < NREQ; i++) if (gnt_o[i]) wcnt[i]++;
    set_wdata();
  endtask

  // Run one burst from the currently set request; request drops once accepted
  task automatic run_burst(input string tag, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (n < budget) begin
      tick(); n++;
      if (busy_o) begin seen = 1'b1; req_i = '0; end
      else if (seen) break;
    end
    check({tag, "_done"}, 64'(seen && !busy_o), 64'd1);
    tick(); tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 64'({request_extmem, write_extmem, busy_o, err_timeout_o, gnt_o, rvalid_o}), 64'd0);
    check({tag, "_addr"}, 64'(addr_extmem), 64'd0);
    check({tag, "_wdata"}, 64'(w_data), 64'd0);
    check({tag, "_rdata"}, 64'(rdata_o), 64'd0);
    check({tag, "_cnt"}, measure_cnt_busy, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; req_i = '0; we_i = '0; addr_i = '0; len_i = '0;
    valid_extmem = 1'b0; data_extmem = '0; mem_en = 1'b1; force_valid = 1'b0;
    clear_logs();
    tick(); tick();
    check_reset("reset");
    rst = 1'b1;
    tick();

    // Read burst, 3 beats, requester 1
    clear_logs();
    req_i[1] = 1'b1; we_i[1] = 1'b0; addr_i[1] = REGION_1; len_i[1] = 8'd3;
    run_burst("rd", 64);
    check("rd_nstrobe", 64'(st_addr.size()), 64'd3);
    for (int k = 0; k < 3; k++) if (k < st_addr.size()) begin
      check($sformatf("rd_addr%0d", k), 64'(st_addr[k]), 64'(REGION_1 + 32'(k)));
      check($sformatf("rd_we%0d", k), 64'(st_we[k]), 64'd0);
    end
    check("rd_nrvalid", 64'(rv_log.size()), 64'd3);
    for (int k = 0; k < 3; k++) if (k < rv_log.size()) begin
      check($sformatf("rd_rv%0d", k), 64'(rv_log[k]), 64'(4'b0010));
      check($sformatf("rd_data%0d", k), 64'(rv_data[k]), 64'((REGION_1 + 32'(k)) ^ 32'h5A5A_5A5A));
    end
    check("rd_cnt", measure_cnt_busy, 64'd9);

    // Write burst, 4 beats, requester 2
    clear_logs();
    req_i[2] = 1'b1; we_i[2] = 1'b1; addr_i[2] = REGION_2; len_i[2] = 8'd4;
    run_burst("wr", 32);
    check("wr_nstrobe", 64'(st_addr.size()), 64'd4);
    check("wr_ngnt", 64'(gnt_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) if (k < st_addr.size() && k < gnt_log.size()) begin
      check($sformatf("wr_addr%0d", k), 64'(st_addr[k]), 64'(REGION_2 + 32'(k)));
      check($sformatf("wr_we%0d", k), 64'(st_we[k]), 64'd1);
      check($sformatf("wr_wd%0d", k), 64'(st_wd[k]), 64'(32'hD002_0000 + 32'(k)));
      check($sformatf("wr_gap%0d", k), 64'(st_cyc[k] - st_cyc[0]), 64'(k));
      check($sformatf("wr_gnt%0d", k), 64'(gnt_log[k]), 64'(4'b0100));
    end
    check("wr_norv", 64'(rv_log.size()), 64'd0);
    check("wr_cnt", measure_cnt_busy, 64'd13);

    // Contention after reset: 0,1,2,3,0 with one idle cycle between grants
    rst = 1'b0; tick(); rst = 1'b1;
    clear_logs();
    we_i = 4'hF; len_i = '{8'd1, 8'd1, 8'd1, 8'd1};
    addr_i = '{REGION_3, REGION_2, REGION_1, REGION_0};
    req_i = 4'hF;
    n = 0;
    while (gnt_log.size() < 5 && n < 64) begin tick(); n++; end
    req_i = '0;
    tick(); tick(); tick();
    check("rr_ngnt", 64'(gnt_log.size()), 64'd5);
    for (int k = 0; k < 5; k++) if (k < gnt_log.size()) begin
      check($sformatf("rr_gnt%0d", k), 64'(gnt_log[k]), 64'(4'b0001 << (k % 4)));
      if (k > 0) check($sformatf("rr_gap%0d", k), 64'(gnt_cyc[k] - gnt_cyc[k-1]), 64'd2);
    end

    // Read timeout: memory never answers
    clear_logs();
    mem_en = 1'b0;
    req_i[3] = 1'b1; we_i[3] = 1'b0; addr_i[3] = REGION_3; len_i[3] = 8'd3;
    run_burst("tmo", 400);
    check("tmo_nstrobe", 64'(st_addr.size()), 64'd1);
    check("tmo_nrv", 64'(rv_log.size()), 64'd1);
    if (rv_log.size() > 0 && st_cyc.size() > 0) begin
      check("tmo_rv", 64'(rv_log[0]), 64'(4'b1000));
      check("tmo_data", 64'(rv_data[0]), 64'd0);
      check("tmo_lat", 64'(rv_cyc[0] - st_cyc[0]), 64'd256);
    end
    check("tmo_err", 64'(err_timeout_o), 64'd1);
    check("tmo_idle", 64'(busy_o), 64'd0);

    // Stray valid while idle is ignored
    clear_logs();
    force_valid = 1'b1; tick(); tick(); tick(); force_valid = 1'b0; tick();
    check("stray_norv", 64'(rv_log.size()), 64'd0);
    check("stray_rdata", 64'(rdata_o), 64'd0);
    mem_en = 1'b1;

    // len 0 issues one beat
    clear_logs();
    req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = REGION_4; len_i[0] = 8'd0;
    run_burst("len0", 32);
    check("len0_nstrobe", 64'(st_addr.size()), 64'd1);
    if (st_addr.size() > 0) check("len0_addr", 64'(st_addr[0]), 64'(REGION_4));

    // Address wrap across 2^32
    clear_logs();
    req_i[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 32'hFFFF_FFFF; len_i[0] = 8'd2;
    run_burst("wrap", 64);
    check("wrap_nstrobe", 64'(st_addr.size()), 64'd2);
    if (st_addr.size() > 1) begin
      check("wrap_addr0", 64'(st_addr[0]), 64'h0000_0000_FFFF_FFFF);
      check("wrap_addr1", 64'(st_addr[1]), 64'd0);
    end
    check("wrap_nrv", 64'(rv_log.size()), 64'd2);
    if (rv_data.size() > 1) begin
      check("wrap_data0", 64'(rv_data[0]), 64'h0000_0000_A5A5_A5A5);
      check("wrap_data1", 64'(rv_data[1]), 64'h0000_0000_5A5A_5A5A);
    end
    check("err_sticky", 64'(err_timeout_o), 64'd1);

    // Reset during beat 2 of a 5-beat read
    clear_logs();
    req_i[2] = 1'b1; we_i[2] = 1'b0; addr_i[2] = REGION_5; len_i[2] = 8'd5;
    n = 0;
    while (st_addr.size() < 2 && n < 64) begin tick(); n++; if (busy_o) req_i = '0; end
    check("mid_reach", 64'(st_addr.size()), 64'd2);
    rst = 1'b0;
    #1;
    check_reset("mid_rst");
    tick(); tick(); tick();
    check("mid_nostrobe", 64'(st_addr.size()), 64'd2);
    check("mid_norv", 64'(rv_log.size()), 64'd1);
    rst = 1'b1;
    clear_logs();
    we_i = 4'hF; len_i = '{8'd1, 8'd1, 8'd1, 8'd1};
    addr_i[0] = REGION_0; addr_i[3] = REGION_3;
    req_i = 4'b1001;
    n = 0;
    while (gnt_log.size() < 1 && n < 16) begin tick(); n++; end
    req_i = '0;
    tick(); tick(); tick();
    check("post_ngnt", 64'(gnt_log.size()), 64'd1);
    if (gnt_log.size() > 0) check("post_gnt", 64'(gnt_log[0]), 64'(4'b0001));
    if (st_addr.size() > 0) check("post_addr", 64'(st_addr[0]), 64'(REGION_0));
    check("post_cnt", measure_cnt_busy, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/extmem_arbiter.md
EXTMEM_ARBITER -- requirements
Module: extmem_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; ADDR_W, default 32, address width; DATA_W, default 32, data width; RD_TIMEOUT, default 255, maximum read-wait cycles.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_i  in  NREQ  per-requester transfer request, level-sensitive.
REQ-005 we_i  in  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-006 addr_i  in  NREQ x ADDR_W  per-requester burst base word address.
REQ-007 len_i  in  NREQ x 8  per-requester burst length in beats; 0 is treated as 1.
REQ-008 wdata_i  in  NREQ x DATA_W  per-requester write data for the current beat.
REQ-009 gnt_o  out  NREQ  one-hot pulse, one per issued beat, to the owning requester.
REQ-010 rvalid_o  out  NREQ  one-hot pulse, one per returned read beat.
REQ-011 rdata_o  out  DATA_W  read data, valid when any rvalid_o bit is high.
REQ-012 request_extmem, write_extmem  out  1 each  external-memory strobe and direction.
REQ-013 addr_extmem, w_data  out  ADDR_W, DATA_W  external-memory address and write data.
REQ-014 valid_extmem, data_extmem  in  1, DATA_W  external read-return strobe and data.
REQ-015 busy_o  out  1  high when the FSM is not in IDLE.
REQ-016 err_timeout_o  out  1  sticky read-timeout flag.
REQ-017 measure_cnt_busy  out  64  count of busy cycles since reset.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BEAT and WAIT_RD.
REQ-019 Arbitration in IDLE: when any req_i bit is high, pick the first high bit searching upward from the round-robin pointer with wrap-around, latch owner/we/base/len, go to BEAT next cycle.
REQ-020 BEAT: drive request_extmem=1 for exactly one cycle, with addr_extmem = base + beat index, write_extmem = latched we, and w_data = wdata_i[owner]; gnt_o[owner]=1 in the same cycle.
REQ-021 Write beats SHALL issue back-to-back, one per cycle; after the last beat the FSM returns to IDLE.
REQ-022 A read beat SHALL move to WAIT_RD.
REQ-023 WAIT_RD on valid_extmem: register data_extmem to rdata_o and pulse rvalid_o[owner] in the following cycle; next state is BEAT if beats remain, otherwise IDLE.
REQ-024 Only one read SHALL be outstanding at a time.
REQ-025 valid_extmem outside WAIT_RD SHALL be ignored.
REQ-026 Timeout: when WAIT_RD lasts RD_TIMEOUT cycles, set err_timeout_o, pulse rvalid_o[owner] with rdata_o=0, abort the remaining beats, and go to IDLE.
REQ-027 Burst end (normal or abort): pointer becomes (owner+1) mod NREQ.
REQ-028 Minimum one IDLE cycle between bursts.
REQ-029 req_i deassertion mid-burst SHALL be ignored; the burst always completes.
REQ-030 Requester inputs other than wdata_i are sampled only in IDLE.
REQ-031 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-032 Beat counter SHALL be 8 bits; len 0 SHALL issue exactly one beat.
REQ-033 All outputs to the external port and requesters SHALL be registered or driven directly from state flops; there are no combinational paths from valid_extmem to request_extmem.
REQ-034 measure_cnt_busy increments each cycle busy_o=1 and saturates at all-ones.

Reset
REQ-035 rst=0 SHALL asynchronously force: state IDLE, pointer 0, all gnt_o/rvalid_o/request_extmem/write_extmem=0, addr_extmem/w_data/rdata_o=0, err_timeout_o=0, measure_cnt_busy=0.
REQ-036 Reset mid-burst SHALL drop the burst with no further strobes; after reset release, arbitration resumes from requester 0.

Structure
REQ-037 Shared package mem_pkg SHALL hold: the NREQ/ADDR_W/DATA_W defaults, the external-memory region offsets (0, 2 MiB, 4 MiB, 6 MiB, 26 MiB, 44 MiB), and the FSM state enum.
REQ-038 A single sub-module rr_arbiter (request vector + pointer -> one-hot winner, combinational) SHALL be used; the FSM, counters and datapath stay in extmem_arbiter.

Verification
REQ-039 Read burst: req_i[1]=1, we=0, addr=0x200000, len=3, memory returning data 2 cycles after strobe -> 3 strobes at 0x200000..0x200002, 3 rvalid_o[1] pulses with matching data, then IDLE.
REQ-040 Write burst: req_i[2]=1, we=1, addr=0x400000, len=4 -> 4 consecutive request_extmem/write_extmem cycles, gnt_o[2] each cycle, w_data equal to per-beat wdata_i.
REQ-041 Contention: req_i=4'b1111 held, len=1 each -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-042 Timeout: read with valid_extmem never asserted -> after 255 WAIT_RD cycles err_timeout_o=1, one rvalid_o with rdata 0, FSM in IDLE; flag stays set.
REQ-043 Reset mid-burst: rst=0 during beat 2 of a len=5 read -> outputs zero immediately; after release, next grant goes to the lowest requesting index; measure_cnt_busy restarts at 0.
REQ-044 Edge cases: len=0 issues exactly one beat; addr=0xFFFFFFFF with len=2 wraps the second beat to 0x00000000.
